contador_pc: RTL
================

CONTADOR_PC -- requirements
Module: contador_pc

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Offset_ext  input  32  sign-extended 13-bit branch offset, two's complement.
REQ-005 SHALL have port Pc_salto  input  32  address of the branch instruction that produced Offset_ext.
REQ-006 SHALL have port Tomar_salto  input  1  branch taken, single-cycle pulse.
REQ-007 SHALL have port Jalr  input  1  register-indirect jump, single-cycle pulse.
REQ-008 SHALL have port Destino_jalr  input  32  jump target, pre-computed by the ALU.
REQ-009 SHALL have port Listo_mem  input  1  instruction memory accepts the current address.
REQ-010 SHALL have port Pc  output  32  current fetch address.
REQ-011 SHALL have port Valido  output  1  Pc is a valid fetch request.
REQ-012 SHALL have port Error  output  1  misaligned redirect detected, sticky.
REQ-013 SHALL have port Num_instr  output  32  count of accepted fetches.

Function
REQ-014 SHALL implement FSM states INICIO, CORRER, DETENIDO; reset enters INICIO.
REQ-015 INICIO SHALL hold Valido=0 for exactly one cycle, then go to CORRER.
REQ-016 CORRER SHALL drive Valido=1; a handshake is a cycle with Valido=1 and Listo_mem=1.
REQ-017 On handshake with no redirect: Pc <= Pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Pc SHALL NOT change while Valido=1 and Listo_mem=0 (address stable under back-pressure).
REQ-019 Branch target SHALL be Pc_salto + Offset_ext, modulo 2^32; jump target SHALL be Destino_jalr with bit 0 forced to 0.
REQ-020 If Jalr and Tomar_salto are both asserted in the same cycle, Jalr SHALL win.
REQ-021 A redirect arriving in a handshake cycle SHALL load Pc with the target on that edge, replacing Pc + 4.
REQ-022 A redirect arriving without a handshake SHALL be stored in a one-entry pending register; the next handshake SHALL load Pc from it and clear it.
REQ-023 A newer redirect SHALL overwrite a pending one; a redirect in the cycle the pending entry is consumed SHALL take precedence over the pending entry.
REQ-024 A target with bits [1:0] != 2'b00 SHALL NOT be stored or loaded; the FSM SHALL go to DETENIDO with Error=1.
REQ-025 DETENIDO SHALL hold Valido=0, Error=1, and freeze Pc and Num_instr until reset.
REQ-026 Num_instr SHALL increment by 1 on every handshake and wrap from 32'hFFFF_FFFF to 0.
REQ-027 Redirect pulses in INICIO or DETENIDO SHALL be ignored.

Reset
REQ-028 When rst_n=0, outputs SHALL be asynchronously set to Pc=PC_RESET, Valido=0, Error=0, Num_instr=0; the pending register SHALL be cleared.
REQ-029 Reset asserted mid-request SHALL drop the request; after release, the first Valido=1 SHALL occur on the second rising edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the constant INSTR_BYTES=4, and the alignment mask 2'b11.
REQ-031 Target selection and alignment checking SHALL be in the sub-module calc_destino (combinational); the FSM, Pc, pending register, and counter SHALL remain in contador_pc.

Verification
REQ-032 Reset release, Listo_mem=1 constant -> Valido=1 from the second edge; Pc sequence 0,4,8,C; Num_instr 1,2,3.
REQ-033 Listo_mem=0 for 3 cycles at Pc=0x10 -> Pc holds 0x10 and Num_instr holds; on ready, Pc goes to 0x14.
REQ-034 Pc_salto=0x20, Offset_ext=0xFFFF_FFF0, Tomar_salto with Listo_mem=0, ready 2 cycles later -> Pc=0x10 after that handshake.
REQ-035 Jalr with Destino_jalr=0x101 and Tomar_salto in the same handshake cycle -> Pc=0x100.
REQ-036 Tomar_salto with target 0x22 -> Error=1, Valido=0, Pc frozen; rst_n pulse clears Error and sets Pc=PC_RESET.
REQ-037 Pc preset near 0xFFFF_FFFC by a redirect, then one handshake -> Pc=0x0000_0000.

Source files
------------

// File: rtl/contador_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : contador_pc_pkg
//  Purpose  : Shared definitions for the program counter: FSM state encoding,
//             the instruction size in bytes and the fetch alignment mask.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package contador_pc_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      INICIO   = 2'd0,
      CORRER   = 2'd1,
      DETENIDO = 2'd2
   } estado_t;

   // Sequential fetch stride
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Any target bit set under this mask is a misaligned fetch address
   localparam logic [1:0]  ALIGN_MASK  = 2'b11;

endpackage : contador_pc_pkg
`default_nettype wire

// File: rtl/contador_pc_calc_destino.sv
`default_nettype none
// ============================================================================
//  Module   : calc_destino
//  Purpose  : Combinational redirect target selection and alignment check.
//             Jalr has priority over a taken branch.
//  Ports    : i_tomar_salto   - branch taken pulse
//             i_jalr          - register-indirect jump pulse
//             i_pc_salto      - address of the branch instruction
//             i_offset_ext    - sign-extended branch offset
//             i_destino_jalr  - ALU-computed jump target
//             o_redir         - a redirect is requested this cycle
//             o_destino       - selected target address
//             o_desalineado   - requested target is not word aligned
//  Revision : 1.0 - initial release
// ============================================================================
module calc_destino
   import contador_pc_pkg::*;
(
   input  logic        i_tomar_salto,
   input  logic        i_jalr,
   input  logic [31:0] i_pc_salto,
   input  logic [31:0] i_offset_ext,
   input  logic [31:0] i_destino_jalr,
   output logic        o_redir,
   output logic [31:0] o_destino,
   output logic        o_desalineado
);

   logic [31:0] w_destino_rama;
   logic [31:0] w_destino_jalr;

   // Branch target wraps naturally modulo 2^32
   assign w_destino_rama = i_pc_salto + i_offset_ext;
   // Jump target always has bit 0 cleared
   assign w_destino_jalr = i_destino_jalr & ~32'h0000_0001;

   assign o_redir       = i_jalr | i_tomar_salto;
   assign o_destino     = i_jalr ? w_destino_jalr : w_destino_rama;
   assign o_desalineado = o_redir && ((o_destino[1:0] & ALIGN_MASK) != 2'b00);

endmodule : calc_destino
`default_nettype wire

// File: rtl/contador_pc.sv
`default_nettype none
// ============================================================================
//  Module   : contador_pc
//  Purpose  : Instruction fetch program counter with back-pressure, branch /
//             jalr redirects, a one-entry pending redirect and a sticky
//             misalignment error.
//  Ports    : clk          - rising-edge clock
//             rst_n        - asynchronous active-low reset
//             Offset_ext   - sign-extended branch offset
//             Pc_salto     - address of the branch instruction
//             Tomar_salto  - branch taken pulse
//             Jalr         - register-indirect jump pulse
//             Destino_jalr - jump target from the ALU
//             Listo_mem    - instruction memory accepts Pc
//             Pc           - current fetch address
//             Valido       - Pc is a valid fetch request
//             Error        - sticky misaligned-redirect flag
//             Num_instr    - count of accepted fetches
//  Revision : 1.0 - initial release
// ============================================================================
module contador_pc
   import contador_pc_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Offset_ext,
   input  logic [31:0] Pc_salto,
   input  logic        Tomar_salto,
   input  logic        Jalr,
   input  logic [31:0] Destino_jalr,
   input  logic        Listo_mem,
   output logic [31:0] Pc,
   output logic        Valido,
   output logic        Error,
   output logic [31:0] Num_instr
);

   estado_t     r_estado;
   logic        r_arranque;     // INICIO has already spent its first edge
   logic        r_pend;
   logic [31:0] r_pend_dir;
   logic [31:0] r_pc;
   logic        r_valido;
   logic        r_error;
   logic [31:0] r_num;

   logic        w_redir;
   logic [31:0] w_destino;
   logic        w_desal;
   logic        w_handshake;

   calc_destino u_calc_destino (
      .i_tomar_salto  (Tomar_salto),
      .i_jalr         (Jalr),
      .i_pc_salto     (Pc_salto),
      .i_offset_ext   (Offset_ext),
      .i_destino_jalr (Destino_jalr),
      .o_redir        (w_redir),
      .o_destino      (w_destino),
      .o_desalineado  (w_desal)
   );

   // Valido is only ever high in CORRER
   assign w_handshake = r_valido & Listo_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado   <= INICIO;
         r_arranque <= 1'b0;
         r_pend     <= 1'b0;
         r_pend_dir <= 32'h0000_0000;
         r_pc       <= PC_RESET;
         r_valido   <= 1'b0;
         r_error    <= 1'b0;
         r_num      <= 32'h0000_0000;
      end else begin
         case (r_estado)
            INICIO: begin
               // The first edge after reset release only arms the start, so
               // the first valid request appears on the second edge.
               if (r_arranque) begin
                  r_estado <= CORRER;
                  r_valido <= 1'b1;
               end else begin
                  r_arranque <= 1'b1;
               end
            end

            CORRER: begin
               if (w_redir && w_desal) begin
                  // Bad target is neither stored nor loaded; Pc freezes here
                  r_estado <= DETENIDO;
                  r_valido <= 1'b0;
                  r_error  <= 1'b1;
                  r_pend   <= 1'b0;
                  if (w_handshake) begin
                     r_num <= r_num + 32'd1;
                  end
               end else if (w_handshake) begin
                  r_num  <= r_num + 32'd1;
                  r_pend <= 1'b0;
                  // A fresh redirect beats the pending one, which beats +4
                  if (w_redir) begin
                     r_pc <= w_destino;
                  end else if (r_pend) begin
                     r_pc <= r_pend_dir;
                  end else begin
                     r_pc <= r_pc + INSTR_BYTES;
                  end
               end else if (w_redir) begin
                  // Newer redirect overwrites any pending entry
                  r_pend     <= 1'b1;
                  r_pend_dir <= w_destino;
               end
            end

            DETENIDO: begin
               r_valido <= 1'b0;
               r_error  <= 1'b1;
            end

            default: begin
               r_estado <= DETENIDO;
               r_valido <= 1'b0;
               r_error  <= 1'b1;
            end
         endcase
      end
   end

   assign Pc        = r_pc;
   assign Valido    = r_valido;
   assign Error     = r_error;
   assign Num_instr = r_num;

endmodule : contador_pc
`default_nettype wire
